// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Edge buffers return data one cycle after the read strobe.
    localparam int READ_LAT = 1;

    // The last operand needs rows+cols cycles to clear the far corner PE.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Tapped delay line: lane i carries the input delayed by DEPTH+i cycles.
import systolic_pkg::*;

module systolic_skew_line #(
    parameter int DEPTH = 1,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din,
    output logic [LANES-1:0] dout
);

    localparam int STAGES = DEPTH + LANES - 1;

    logic [STAGES-1:0] sr;
    logic [STAGES:0]   nxt;

    assign nxt = {sr, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= nxt[STAGES-1:0];
        end
    end

    // sr[j] holds din delayed by j+1 cycles.
    assign dout = sr[STAGES-1:DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary systolic array: feed, flush, drain, done.
import systolic_pkg::*;

module systolic_seq_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8,
    localparam int DR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            start_err,
    output logic            acc_clear,
    output logic            rd_en,
    output logic [K_W-1:0]  rd_addr,
    output logic [ROWS-1:0] row_valid,
    output logic [COLS-1:0] col_valid,
    output logic [DR_W-1:0] drain_row,
    output logic            res_valid,
    input  logic            res_ready,
    output seq_state_t      dbg_state
);

    localparam int FLUSH_CYC = flush_cycles(ROWS, COLS);
    localparam int FC_W      = $clog2(FLUSH_CYC + 1);

    seq_state_t     state;
    logic [K_W-1:0] k_len_q;
    logic [FC_W-1:0] flush_cnt;
    logic           skew_clr;

    // Handshake: a result row transfers on any cycle where res_valid && res_ready;
    // res_valid never drops while waiting and drain_row stays stable until accepted.

    assign skew_clr  = abort && (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_len_q   <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            acc_clear <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            res_valid <= 1'b0;
            drain_row <= '0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            acc_clear <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                flush_cnt <= '0;
                busy      <= 1'b0;
                rd_en     <= 1'b0;
                rd_addr   <= '0;
                res_valid <= 1'b0;
                drain_row <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (k_len != '0) begin
                                state     <= FEED;
                                k_len_q   <= k_len;
                                busy      <= 1'b1;
                                acc_clear <= 1'b1;
                                rd_en     <= 1'b1;
                                rd_addr   <= '0;
                            end else begin
                                start_err <= 1'b1;
                            end
                        end
                    end
                    FEED: begin
                        // rd_addr is the k counter; comparing against k_len-1 avoids wrap at max length.
                        if (rd_addr == k_len_q - 1'b1) begin
                            state     <= FLUSH;
                            rd_en     <= 1'b0;
                            rd_addr   <= '0;
                            flush_cnt <= '0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                            state     <= DRAIN;
                            flush_cnt <= '0;
                            res_valid <= 1'b1;
                            drain_row <= '0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (res_ready) begin
                            if (drain_row == DR_W'(ROWS - 1)) begin
                                state     <= DONE;
                                res_valid <= 1'b0;
                                drain_row <= '0;
                                done      <= 1'b1;
                            end else begin
                                drain_row <= drain_row + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    systolic_skew_line #(
        .DEPTH (READ_LAT),
        .LANES (ROWS)
    ) u_row_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skew_clr),
        .din   (rd_en),
        .dout  (row_valid)
    );

    systolic_skew_line #(
        .DEPTH (READ_LAT),
        .LANES (COLS)
    ) u_col_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skew_clr),
        .din   (rd_en),
        .dout  (col_valid)
    );

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an output-stationary ROWS x COLS systolic array of MAC processing elements.
- On start, it clears the accumulators and issues K operand reads to the A and B edge buffers. It then generates per-row and per-column skewed valid strobes so each operand wavefront enters the array diagonally.
- After issuing, it waits for the array to flush, then drains results row by row over a valid/ready handshake and pulses done.

Parameters:
- ROWS, 4, array rows; A-buffer lanes.
- COLS, 4, array columns; B-buffer lanes.
- K_W, 8, width of the K-length and K-address fields.
- FLUSH_CYC, ROWS+COLS, cycles in FLUSH; derived, not to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a tile computation; sampled only in IDLE.
- k_len  in  K_W  reduction length; sampled with start.
- abort  in  1  synchronous abort; has effect from any non-IDLE state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- start_err  out  1  one-cycle pulse when start arrives with k_len==0.
- acc_clear  out  1  one-cycle pulse that clears all PE accumulators.
- rd_en  out  1  A/B buffer read strobe; buffers have 1-cycle read latency.
- rd_addr  out  K_W  k index of the current read.
- row_valid  out  ROWS  skewed valid into each array row.
- col_valid  out  COLS  skewed valid into each array column.
- drain_row  out  $clog2(ROWS)  row index currently being presented for drain.
- res_valid  out  1  a result row is available on the drain bus.
- res_ready  in  1  downstream accepts the result row.

Behaviour:
- Reset: state IDLE. busy, done, start_err, acc_clear, rd_en, res_valid are 0. rd_addr, drain_row are 0. row_valid and col_valid are all 0. Skew registers are cleared.
- Outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- States: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - start && k_len!=0 -> FEED; latch k_len; k=0; acc_clear=1 in the first FEED cycle.
  - start && k_len==0 -> stay in IDLE; start_err=1 for one cycle.
- FEED:
  - rd_en=1 and rd_addr=k every cycle; k increments.
  - After the cycle with k==k_len-1 -> FLUSH.
  - FEED lasts exactly k_len cycles.
- Skew:
  - issue = rd_en delayed by 1 cycle, matching buffer read latency.
  - row_valid[r] = issue delayed by r cycles.
  - col_valid[c] = issue delayed by c cycles.
  - Using start-sample edge = cycle T0 (FEED begins at T1): row_valid[r] is high in cycles T2+r .. T1+r+k_len.
- FLUSH:
  - Counter runs 0..FLUSH_CYC-1, then -> DRAIN.
  - Skew lines keep shifting, so all strobes are 0 before DRAIN.
- DRAIN:
  - res_valid=1 throughout; drain_row starts at 0.
  - On res_valid && res_ready, drain_row increments.
  - On acceptance with drain_row==ROWS-1 -> DONE.
  - While res_ready is low, drain_row is held.
- DONE: done=1 for one cycle -> IDLE. busy is high in this cycle.
- start while busy: ignored; never queued.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - Skew lines and all counters are cleared.
  - done is not pulsed.
  - abort wins over every simultaneous transition, including DRAIN's final acceptance.
- k_len=2^K_W-1: the k counter must not wrap before the FEED exit compare.
- Asynchronous reset mid-operation: returns to the reset values immediately; no done is produced.

Decomposition:
- Package systolic_pkg:
  - state enum seq_state_t {IDLE, FEED, FLUSH, DRAIN, DONE}.
  - Constant READ_LAT=1.
  - Function flush_cycles(rows, cols).
- Sub-module systolic_skew_line:
  - Parameters DEPTH and LANES.
  - Lane i outputs the input delayed by i+1 cycles.
  - Has a synchronous clear for abort.
  - Instantiated twice: ROWS lanes and COLS lanes.

Test Plan:
- Basic tile:
  - Stimulus: reset; start with k_len=3, res_ready tied 1.
  - Response: acc_clear at T1; rd_en T1..T3 with rd_addr 0,1,2; row_valid[3] high T5..T7; DRAIN rows 0..3 in 4 cycles; done exactly one cycle; busy low afterward.
- Drain backpressure:
  - Stimulus: k_len=1; res_ready low for 3 cycles at drain_row=1.
  - Response: drain_row holds 1 and res_valid stays 1; done follows 3 cycles after res_ready rises.
- Zero length:
  - Stimulus: start with k_len=0.
  - Response: one-cycle start_err; busy stays 0; no rd_en.
- Start while busy:
  - Stimulus: second start pulse during FEED.
  - Response: ignored; exactly one done; rd_en count equals k_len.
- Abort:
  - Stimulus: abort during FEED at k=2 (k_len=5).
  - Response: IDLE the next cycle; all valids 0 within 1 cycle; no done. A following start with k_len=2 completes normally.
- Abort race:
  - Stimulus: abort coincident with the final res_ready acceptance.
  - Response: IDLE, no done. Then assert and release rst_n mid-FLUSH: all outputs return to the reset values.
